carry_chain_add: RTL

CARRY_CHAIN_ADD -- requirements
Module: carry_chain_add

---
 rtl/carry_chain_add_pkg.sv | 16 +
 rtl/carry_chain_add_if.sv | 24 ++
 rtl/carry_chain_add_chunk.sv | 47 ++++
 rtl/carry_chain_add.sv | 110 +++++++++++
 4 files changed

// File: rtl/carry_chain_add_pkg.sv
// rtl/carry_chain_add_pkg.sv - shared constants and sizing helpers for the chunked carry-chain adder
package carry_chain_pkg;

    localparam int CHUNK_DEFAULT = 4;

    // Pipeline depth: one stage per chunk of operand bits.
    function automatic int stage_count(input int width, input int chunk);
        return width / chunk;
    endfunction

    // Legal only when the operand splits into whole, non-empty chunks.
    function automatic bit width_fits(input int width, input int chunk);
        return (chunk >= 1) && (width >= chunk) && ((width % chunk) == 0);
    endfunction

endpackage

// File: rtl/carry_chain_add_if.sv
// rtl/carry_chain_add_if.sv - operand/result bundle for the carry-chain adder
interface carry_chain_add_if #(
    parameter int WIDTH = 16
);
    logic             CE;
    logic             IV;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             CI;
    logic             SUB;
    logic [WIDTH-1:0] O;
    logic             CO;
    logic             OV;

    modport master (
        output CE, IV, A, B, CI, SUB,
        input  O, CO, OV
    );

    modport slave (
        input  CE, IV, A, B, CI, SUB,
        output O, CO, OV
    );
endinterface

// File: rtl/carry_chain_add_chunk.sv
// rtl/carry_chain_add_chunk.sv - one registered CHUNK-wide ripple slice of the carry chain
module carry_chunk #(
    parameter int CHUNK = 4
) (
    input  logic             C,
    input  logic             CLR,
    input  logic             CE,
    input  logic             vi,
    input  logic             ci,
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    output logic [CHUNK-1:0] sum_q,
    output logic             co_q,
    output logic             vo_q
);

    logic [CHUNK-1:0] p;
    logic [CHUNK-1:0] s;
    logic [CHUNK:0]   c;

    // Per-bit propagate and sum, carry rippling LSB to MSB inside the slice.
    always_comb begin
        p    = '0;
        s    = '0;
        c    = '0;
        c[0] = ci;
        for (int i = 0; i < CHUNK; i++) begin
            p[i]     = a[i] ^ b[i];
            s[i]     = p[i] ^ c[i];
            c[i + 1] = (a[i] & b[i]) | (p[i] & c[i]);
        end
    end

    // Slice register: sum, carry-out and the valid bit travel together.
    always_ff @(posedge C or posedge CLR) begin
        if (CLR) begin
            sum_q <= '0;
            co_q  <= 1'b0;
            vo_q  <= 1'b0;
        end else if (CE) begin
            sum_q <= s;
            co_q  <= c[CHUNK];
            vo_q  <= vi;
        end
    end

endmodule

// File: rtl/carry_chain_add.sv
// rtl/carry_chain_add.sv - pipelined adder/subtractor resolving CHUNK bits of carry per stage
module carry_chain_add
    import carry_chain_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int CHUNK = CHUNK_DEFAULT
) (
    input logic               C,
    input logic               CLR,
    carry_chain_add_if.slave  bus
);

    localparam int STAGES = stage_count(WIDTH, CHUNK);

    if (!width_fits(WIDTH, CHUNK)) begin : g_bad_params
        $error("carry_chain_add: WIDTH must be a positive multiple of CHUNK");
    end

    // Subtraction is A + ~B + 1; CI only matters in add mode.
    logic [WIDTH-1:0] b_eff;
    logic             ci_eff;
    assign b_eff  = bus.SUB ? ~bus.B : bus.B;
    assign ci_eff = bus.SUB | bus.CI;

    logic [CHUNK-1:0]  sum_q [STAGES];
    logic [STAGES-1:0] co_q;
    logic [STAGES-1:0] vo_q;
    logic [WIDTH-1:0]  o_vec;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        logic [CHUNK-1:0] a_in;
        logic [CHUNK-1:0] b_in;
        logic             ci_in;
        logic             vi_in;

        if (k == 0) begin : g_first
            assign a_in  = bus.A[CHUNK-1:0];
            assign b_in  = b_eff[CHUNK-1:0];
            assign ci_in = ci_eff;
            assign vi_in = bus.IV;
        end else begin : g_skew
            logic [CHUNK-1:0] a_dly [k];
            logic [CHUNK-1:0] b_dly [k];

            // Input skew: operand chunk k waits k enabled cycles for its carry.
            always_ff @(posedge C or posedge CLR) begin
                if (CLR) begin
                    for (int i = 0; i < k; i++) begin
                        a_dly[i] <= '0;
                        b_dly[i] <= '0;
                    end
                end else if (bus.CE) begin
                    a_dly[0] <= bus.A[k*CHUNK +: CHUNK];
                    b_dly[0] <= b_eff[k*CHUNK +: CHUNK];
                    for (int i = 1; i < k; i++) begin
                        a_dly[i] <= a_dly[i - 1];
                        b_dly[i] <= b_dly[i - 1];
                    end
                end
            end

            assign a_in  = a_dly[k - 1];
            assign b_in  = b_dly[k - 1];
            assign ci_in = co_q[k - 1];
            assign vi_in = vo_q[k - 1];
        end

        carry_chunk #(
            .CHUNK (CHUNK)
        ) u_chunk (
            .C     (C),
            .CLR   (CLR),
            .CE    (bus.CE),
            .vi    (vi_in),
            .ci    (ci_in),
            .a     (a_in),
            .b     (b_in),
            .sum_q (sum_q[k]),
            .co_q  (co_q[k]),
            .vo_q  (vo_q[k])
        );

        if (k == STAGES - 1) begin : g_last
            assign o_vec[k*CHUNK +: CHUNK] = sum_q[k];
        end else begin : g_deskew
            logic [CHUNK-1:0] r_dly [STAGES-1-k];

            // Output deskew: early chunks wait so the whole result lands at once.
            always_ff @(posedge C or posedge CLR) begin
                if (CLR) begin
                    for (int i = 0; i < STAGES - 1 - k; i++) begin
                        r_dly[i] <= '0;
                    end
                end else if (bus.CE) begin
                    r_dly[0] <= sum_q[k];
                    for (int i = 1; i < STAGES - 1 - k; i++) begin
                        r_dly[i] <= r_dly[i - 1];
                    end
                end
            end

            assign o_vec[k*CHUNK +: CHUNK] = r_dly[STAGES-2-k];
        end
    end

    assign bus.O  = o_vec;
    assign bus.CO = co_q[STAGES-1];
    assign bus.OV = vo_q[STAGES-1];

endmodule
